// File: rtl/enemy_hit_detector_if.sv
// ---------------------------------------------------------------------------
// enemy_hit_detector_if
//   Groups the raster-side inputs and collision-side outputs of
//   enemy_hit_detector into one bundle.
//
//   Signals:
//     startOfFrame  one-cycle pulse at start of each frame
//     pixelX/Y      current raster position (11-bit signed)
//     topLeftX/Y    enemy sprite top-left corner (11-bit signed)
//     enemyDR       enemy draw request for the current pixel
//     obstacleDR    wall/brick draw request for the current pixel
//     bombDR        bomb draw request (only with ENEMY_HIT_BOMB_EN)
//     collision     one-cycle hit pulse, at most one per frame
//     HitEdgeCode   one-hot edge of the last reported hit
//     hitMask       OR of all edge codes seen this frame
//     state         frame FSM state (0 = armed, 1 = reported)
//
//   Handshake: there is no back-pressure. Every input is a per-pixel
//   sample taken on every rising clock edge; collision is a pulse that
//   is valid for exactly the one cycle it is high.
//
//   Optional feature macro: ENEMY_HIT_BOMB_EN (adds bombDR).
// ---------------------------------------------------------------------------
interface enemy_hit_detector_if;
    logic               startOfFrame;
    logic signed [10:0] pixelX;
    logic signed [10:0] pixelY;
    logic signed [10:0] topLeftX;
    logic signed [10:0] topLeftY;
    logic               enemyDR;
    logic               obstacleDR;
`ifdef ENEMY_HIT_BOMB_EN
    logic               bombDR;
`endif
    logic               collision;
    logic [3:0]         HitEdgeCode;
    logic [3:0]         hitMask;
    logic               state;

    modport master (
        output startOfFrame, pixelX, pixelY, topLeftX, topLeftY,
        output enemyDR, obstacleDR,
`ifdef ENEMY_HIT_BOMB_EN
        output bombDR,
`endif
        input  collision, HitEdgeCode, hitMask, state
    );

    modport slave (
        input  startOfFrame, pixelX, pixelY, topLeftX, topLeftY,
        input  enemyDR, obstacleDR,
`ifdef ENEMY_HIT_BOMB_EN
        input  bombDR,
`endif
        output collision, HitEdgeCode, hitMask, state
    );
endinterface

// File: rtl/enemy_hit_detector.sv
// ---------------------------------------------------------------------------
// enemy_hit_detector
//   Per-pixel collision classifier for one enemy sprite. When the enemy's
//   draw request overlaps an obstacle draw request, the overlapping pixel
//   is classified by which sprite edge band it lies in, and the first
//   single-edge hit of each frame is reported as a one-cycle pulse.
//
//   Ports:
//     clk    system clock
//     reset  asynchronous reset, active-high
//     bus    enemy_hit_detector_if.slave (raster inputs, hit outputs,
//            FSM state for debug)
//
//   Pipeline: pixel sampled at edge N -> stage 1 (hit, offsets) ->
//   stage 2 (hit, edge code) -> collision shows combinationally from
//   stage 2 during cycle N+2. HitEdgeCode/hitMask update on the edge
//   that closes the pulse cycle.
//
//   Optional feature macro: ENEMY_HIT_BOMB_EN -- bombDR also counts as an
//   obstacle.
// ---------------------------------------------------------------------------
module enemy_hit_detector #(
    parameter int OBJECT_WIDTH_X = 32,
    parameter int OBJECT_HIGHT_Y = 32,
    parameter int EDGE_MARGIN    = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    enemy_hit_detector_if.slave  bus
);
    typedef enum logic {
        ARMED_ST    = 1'b0,
        REPORTED_ST = 1'b1
    } state_t;

    localparam logic signed [10:0] ZERO_S   = 11'sd0;
    localparam logic signed [10:0] WIDTH_S  = 11'(OBJECT_WIDTH_X);
    localparam logic signed [10:0] HEIGHT_S = 11'(OBJECT_HIGHT_Y);
    localparam logic signed [10:0] MARGIN_S = 11'(EDGE_MARGIN);
    localparam logic signed [10:0] RIGHT_S  = 11'(OBJECT_WIDTH_X - EDGE_MARGIN);
    localparam logic signed [10:0] BOTTOM_S = 11'(OBJECT_HIGHT_Y - EDGE_MARGIN);

    // ---------------- stage 1: overlap and sprite-relative offset ----------
    logic               blocker;
    logic               hit1;
    logic signed [10:0] off_x1;
    logic signed [10:0] off_y1;

`ifdef ENEMY_HIT_BOMB_EN
    assign blocker = bus.obstacleDR | bus.bombDR;
`else
    assign blocker = bus.obstacleDR;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit1   <= 1'b0;
            off_x1 <= '0;
            off_y1 <= '0;
        end else begin
            hit1   <= bus.enemyDR & blocker;
            off_x1 <= bus.pixelX - bus.topLeftX;
            off_y1 <= bus.pixelY - bus.topLeftY;
        end
    end

    // ---------------- edge classification ----------------------------------
    logic       in_box;
    logic [3:0] flags;   // bit order matches the code: {LEFT, TOP, RIGHT, BOTTOM}
    logic [3:0] code1;

    always_comb begin
        in_box = (off_x1 >= ZERO_S) && (off_x1 < WIDTH_S) &&
                 (off_y1 >= ZERO_S) && (off_y1 < HEIGHT_S);
        flags  = {off_x1 <  MARGIN_S,
                  off_y1 <  MARGIN_S,
                  off_x1 >= RIGHT_S,
                  off_y1 >= BOTTOM_S};
        code1  = 4'b0000;
        // Corners (two flags) and the interior (no flags) are ambiguous
        // and deliberately classify as "no edge".
        if (in_box && (flags != 4'b0000) && ((flags & (flags - 4'd1)) == 4'b0000))
            code1 = flags;
    end

    // ---------------- stage 2 ----------------------------------------------
    logic       hit2;
    logic [3:0] code2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit2  <= 1'b0;
            code2 <= 4'b0000;
        end else begin
            hit2  <= hit1;
            code2 <= code1;
        end
    end

    // ---------------- frame FSM --------------------------------------------
    state_t     state, state_next;
    logic [3:0] hit_edge_code, hit_edge_code_next;
    logic [3:0] hit_mask, hit_mask_next;
    logic       pulse;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ARMED_ST;
            hit_edge_code <= 4'b0000;
            hit_mask      <= 4'b0000;
        end else begin
            state         <= state_next;
            hit_edge_code <= hit_edge_code_next;
            hit_mask      <= hit_mask_next;
        end
    end

    always_comb begin
        state_next         = state;
        hit_edge_code_next = hit_edge_code;
        hit_mask_next      = hit_mask;
        pulse              = 1'b0;
        if (bus.startOfFrame) begin
            // Frame boundary wins over a hit sitting in stage 2 this cycle.
            state_next    = ARMED_ST;
            hit_mask_next = 4'b0000;
        end else if (hit2 && (code2 != 4'b0000)) begin
            hit_mask_next = hit_mask | code2;
            if (state == ARMED_ST) begin
                pulse              = 1'b1;
                hit_edge_code_next = code2;
                state_next         = REPORTED_ST;
            end
        end
    end

    assign bus.collision   = pulse;
    assign bus.HitEdgeCode = hit_edge_code;
    assign bus.hitMask     = hit_mask;
    assign bus.state       = state;
endmodule

// File: tb/tb_enemy_hit_detector.sv
// ---------------------------------------------------------------------------
// tb_enemy_hit_detector
//   Directed bench for enemy_hit_detector. Stimulus tasks drive one pixel
//   per cycle (just after the rising edge) and push expected pulses and
//   expected register snapshots into queues; a monitor on the falling
//   edge pops and compares them.
// ---------------------------------------------------------------------------
module tb_enemy_hit_detector;
    logic clk;
    logic rst;
    int   cyc;
    int   n_vec;
    int   n_miss;

    // expected pulse: {cycle[31:0], code[3:0]}
    logic [35:0] exp_q[$];
    // expected snapshot: {cycle[31:0], HitEdgeCode[3:0], hitMask[3:0]}
    logic [39:0] chk_q[$];

    localparam logic [3:0] TOP    = 4'b0100;
    localparam logic [3:0] RIGHT  = 4'b0010;
    localparam logic [3:0] LEFT   = 4'b1000;
    localparam logic [3:0] BOTTOM = 4'b0001;
    localparam logic [3:0] NONE   = 4'b0000;

    enemy_hit_detector_if bus ();

    enemy_hit_detector dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    // ---------------- clock / reset ----------------------------------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- driver tasks -----------------------------------------
    task automatic clear_inputs();
        bus.startOfFrame = 1'b0;
        bus.enemyDR      = 1'b0;
        bus.obstacleDR   = 1'b0;
`ifdef ENEMY_HIT_BOMB_EN
        bus.bombDR       = 1'b0;
`endif
    endtask

    task automatic drive(input int x, input int y, input logic edr,
                         input logic odr, input logic bdr, input logic sof,
                         input logic [3:0] exp_code);
        @(posedge clk);
        #1;
        bus.pixelX       = 11'(x);
        bus.pixelY       = 11'(y);
        bus.enemyDR      = edr;
        bus.obstacleDR   = odr;
        bus.startOfFrame = sof;
`ifdef ENEMY_HIT_BOMB_EN
        bus.bombDR       = bdr;
`else
        if (bdr) $display("note: bombDR ignored in this build");
`endif
        if (exp_code != NONE)
            exp_q.push_back({32'(cyc + 2), exp_code});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            clear_inputs();
        end
    endtask

    task automatic sof();
        drive(0, 0, 1'b0, 1'b0, 1'b0, 1'b1, NONE);
    endtask

    task automatic check_status(input logic [3:0] hec, input logic [3:0] mask);
        @(posedge clk);
        #1;
        clear_inputs();
        chk_q.push_back({32'(cyc), hec, mask});
    endtask

    // ---------------- monitor / scoreboard ---------------------------------
    logic       code_pend;
    logic [3:0] code_exp;
    initial code_pend = 1'b0;

    always @(negedge clk) begin
        logic [35:0] e;
        logic [39:0] s;
        if (code_pend) begin
            n_vec++;
            if (bus.HitEdgeCode !== code_exp) begin
                n_miss++;
                $display("FAIL pulse_code @%0d: HitEdgeCode=%b want %b", cyc, bus.HitEdgeCode, code_exp);
            end
            code_pend = 1'b0;
        end
        if (exp_q.size() != 0 && exp_q[0][35:4] == 32'(cyc)) begin
            e = exp_q.pop_front();
            n_vec++;
            if (bus.collision !== 1'b1) begin
                n_miss++;
                $display("FAIL pulse_missing @%0d: collision=%b want 1", cyc, bus.collision);
            end else begin
                code_exp  = e[3:0];
                code_pend = 1'b1;
            end
        end else if (bus.collision !== 1'b0) begin
            n_vec++;
            n_miss++;
            $display("FAIL pulse_unexpected @%0d: collision=%b want 0", cyc, bus.collision);
        end
        if (chk_q.size() != 0 && chk_q[0][39:8] == 32'(cyc)) begin
            s = chk_q.pop_front();
            n_vec++;
            if (bus.HitEdgeCode !== s[7:4] || bus.hitMask !== s[3:0]) begin
                n_miss++;
                $display("FAIL status @%0d: HitEdgeCode=%b hitMask=%b want %b %b",
                         cyc, bus.HitEdgeCode, bus.hitMask, s[7:4], s[3:0]);
            end
        end
    end

    // ---------------- directed sequence ------------------------------------
    initial begin
        n_vec  = 0;
        n_miss = 0;
        rst    = 1'b1;
        bus.pixelX   = '0;
        bus.pixelY   = '0;
        bus.topLeftX = 11'sd15;
        bus.topLeftY = 11'sd48;
        clear_inputs();
        idle(2);
        check_status(NONE, NONE);            // reset state
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        // TOP edge at (20,48): offsets (5,0)
        sof();
        drive(20, 48, 1'b1, 1'b1, 1'b0, 1'b0, TOP);
        idle(3);
        check_status(TOP, TOP);

        // RIGHT edge (31,12) in the same frame: no pulse, mask grows
        drive(46, 60, 1'b1, 1'b1, 1'b0, 1'b0, NONE);
        idle(3);
        check_status(TOP, TOP | RIGHT);

        // new frame: same pixel now reports
        sof();
        drive(46, 60, 1'b1, 1'b1, 1'b0, 1'b0, RIGHT);
        idle(3);
        check_status(RIGHT, RIGHT);

        // corner (0,0) and interior (15,12): code 0
        sof();
        drive(15, 48, 1'b1, 1'b1, 1'b0, 1'b0, NONE);
        drive(30, 60, 1'b1, 1'b1, 1'b0, 1'b0, NONE);
        idle(3);
        check_status(RIGHT, NONE);

        // BOTTOM (5,31): needs both draw requests
        drive(20, 79, 1'b1, 1'b0, 1'b0, 1'b0, NONE);
        idle(3);
        check_status(RIGHT, NONE);
        drive(20, 79, 1'b1, 1'b1, 1'b0, 1'b0, BOTTOM);
        idle(3);
        check_status(BOTTOM, BOTTOM);

        // hit reaching stage 2 in the startOfFrame cycle is dropped
        sof();
        drive(20, 48, 1'b1, 1'b1, 1'b0, 1'b0, NONE);
        idle(1);
        sof();
        idle(2);
        check_status(BOTTOM, NONE);
        // hit entering stage 1 with startOfFrame lands in the new frame
        drive(16, 60, 1'b1, 1'b1, 1'b0, 1'b1, LEFT);
        idle(3);
        check_status(LEFT, LEFT);

        // reset one cycle after a hit is presented: hit lost
        sof();
        drive(46, 60, 1'b1, 1'b1, 1'b0, 1'b0, NONE);
        @(posedge clk);
        #1;
        clear_inputs();
        rst = 1'b1;
        check_status(NONE, NONE);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(4);
        check_status(NONE, NONE);

`ifdef ENEMY_HIT_BOMB_EN
        // bomb blocks like a wall
        sof();
        drive(20, 48, 1'b1, 1'b0, 1'b1, 1'b0, TOP);
        idle(3);
        check_status(TOP, TOP);
`endif

        idle(5);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
